// File: rtl/byte_unstrip_ctrl.sv
// -----------------------------------------------------------------------------
// byte_unstrip_ctrl
//
// Receive-side lane controller for a 2-lane PHY. The two lanes deliver one
// byte each per word; a word lasts two clk_2f cycles. The block locks onto
// the word boundary using COM symbols present on both lanes. Once locked, it
// merges the lanes into one byte stream, lane 0 first and lane 1 second.
//
// Lane valid mismatches are counted. A run of ERR_LIMIT consecutive mismatch
// words sends the controller back to the boundary search.
//
// Optional feature: define BYTE_UNSTRIP_CTRL_STATS_EN to add the word_cnt
// output. word_cnt is a 16-bit wrapping count of forwarded words.
//
// Ports:
//   clk_2f       in   byte clock (twice the lane word rate)
//   reset        in   synchronous, active-high
//   data_par_0   in   [7:0] lane 0 byte, stable for one word
//   data_par_1   in   [7:0] lane 1 byte, same timing as lane 0
//   valid_par_0  in   lane 0 valid
//   valid_par_1  in   lane 1 valid
//   data_out     out  [7:0] unstripped byte stream (IDLE_SYM when not valid)
//   valid_out    out  data_out qualifier
//   lane_sel     out  lane of the byte on data_out; holds while valid_out=0
//   synced       out  high while word alignment is locked
//   err_cnt      out  [ERR_W-1:0] saturating count of mismatch words
//   err_pulse    out  one-cycle pulse per mismatch word
//   word_cnt     out  [15:0] forwarded words (BYTE_UNSTRIP_CTRL_STATS_EN only)
// -----------------------------------------------------------------------------
module byte_unstrip_ctrl #(
  parameter logic [7:0] COM_SYM    = 8'hBC,
  parameter logic [7:0] IDLE_SYM   = 8'h7C,
  parameter int         SYNC_WORDS = 4,
  parameter int         ERR_LIMIT  = 3,
  parameter int         ERR_W      = 4
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic [7:0]       data_par_0,
  input  logic [7:0]       data_par_1,
  input  logic             valid_par_0,
  input  logic             valid_par_1,
  output logic [7:0]       data_out,
  output logic             valid_out,
  output logic             lane_sel,
  output logic             synced,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_pulse
`ifdef BYTE_UNSTRIP_CTRL_STATS_EN
  ,
  output logic [15:0]      word_cnt
`endif
);

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // run_cnt counts COM cycles, up to 2*15 = 30.
  localparam int              RUN_W    = 5;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(2 * SYNC_WORDS - 1);
  localparam logic [3:0]       ERR_LIM  = 4'(ERR_LIMIT);

  state_t           state_q, state_d;
  logic             phase_q, phase_d;      // 0 = first cycle of a word
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [3:0]       err_run_q, err_run_d;
  logic [7:0]       hold1_q, hold1_d;      // lane 1 byte of the current word
  logic             fwd_q, fwd_d;          // current word is being forwarded
  logic [7:0]       data_out_q, data_out_d;
  logic             valid_out_q, valid_out_d;
  logic             lane_sel_q, lane_sel_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [15:0]      word_cnt_q, word_cnt_d;

  logic is_com;
  logic both_valid;
  logic one_valid;

  assign is_com     = valid_par_0 && valid_par_1 &&
                      (data_par_0 == COM_SYM) && (data_par_1 == COM_SYM);
  assign both_valid = valid_par_0 && valid_par_1;
  assign one_valid  = valid_par_0 ^ valid_par_1;

  always_comb begin
    // NOTE: every next-state signal is given a default before any branch, so
    // no path through this block can leave one unassigned and infer a latch.
    state_d     = state_q;
    phase_d     = ~phase_q;
    run_cnt_d   = run_cnt_q;
    err_run_d   = err_run_q;
    hold1_d     = hold1_q;
    fwd_d       = fwd_q;
    data_out_d  = IDLE_SYM;
    valid_out_d = 1'b0;
    lane_sel_d  = lane_sel_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    word_cnt_d  = word_cnt_q;

    unique case (state_q)
      ST_SYNC: begin
        fwd_d     = 1'b0;
        err_run_d = '0;
        if (is_com) begin
          run_cnt_d = run_cnt_q + 1'b1;
          // The first COM cycle of a run is by definition phase 0.
          if (run_cnt_q == '0) phase_d = 1'b1;
          // Leaving on the last COM cycle makes the first ACTIVE cycle a
          // phase-0 cycle, because the run length is even.
          if (run_cnt_q == RUN_LAST) begin
            state_d   = ST_ACTIVE;
            run_cnt_d = '0;
          end
        end else begin
          run_cnt_d = '0;
        end
      end

      ST_ACTIVE: begin
        if (!phase_q) begin
          fwd_d = 1'b0;
          if (both_valid && !is_com) begin
            data_out_d  = data_par_0;
            valid_out_d = 1'b1;
            lane_sel_d  = 1'b0;
            hold1_d     = data_par_1;
            fwd_d       = 1'b1;
            err_run_d   = '0;
            word_cnt_d  = word_cnt_q + 16'd1;
          end else if (is_com) begin
            err_run_d = '0;
          end else if (one_valid) begin
            err_pulse_d = 1'b1;
            err_run_d   = err_run_q + 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
          end
          // Neither lane valid: idle word, err_run left unchanged.
        end else begin
          // Phase 1: lane inputs are ignored; only the captured word matters.
          if (fwd_q) begin
            data_out_d  = hold1_q;
            valid_out_d = 1'b1;
            lane_sel_d  = 1'b1;
          end
          fwd_d = 1'b0;
          if (err_run_q >= ERR_LIM) begin
            state_d   = ST_SYNC;
            err_run_d = '0;
            run_cnt_d = '0;
          end
        end
      end

      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk_2f) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this clock edge.
    if (reset) begin
      state_q     <= ST_SYNC;
      phase_q     <= 1'b0;
      run_cnt_q   <= '0;
      err_run_q   <= '0;
      hold1_q     <= '0;
      fwd_q       <= 1'b0;
      data_out_q  <= IDLE_SYM;
      valid_out_q <= 1'b0;
      lane_sel_q  <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      run_cnt_q   <= run_cnt_d;
      err_run_q   <= err_run_d;
      hold1_q     <= hold1_d;
      fwd_q       <= fwd_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      lane_sel_q  <= lane_sel_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign lane_sel  = lane_sel_q;
  assign synced    = (state_q == ST_ACTIVE);
  assign err_cnt   = err_cnt_q;
  assign err_pulse = err_pulse_q;

`ifdef BYTE_UNSTRIP_CTRL_STATS_EN
  assign word_cnt = word_cnt_q;
`else
  // The counter has no reader in this build and is optimised away.
  logic unused_word_cnt;
  assign unused_word_cnt = ^word_cnt_q;
`endif

endmodule

// File: tb/tb_byte_unstrip_ctrl.sv
// -----------------------------------------------------------------------------
// tb_byte_unstrip_ctrl
//
// Drives whole lane words (two clk_2f cycles each) into byte_unstrip_ctrl.
// It checks every output cycle against a word-level reference model. The
// model tracks the lock state, the COM-word run, the error run, the error
// count and the byte expected on the following cycle.
// -----------------------------------------------------------------------------
module tb_byte_unstrip_ctrl;

  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;
  localparam int         SW   = 4;
  localparam int         EL   = 3;

  logic       clk_2f = 1'b0;
  logic       reset  = 1'b1;
  logic [7:0] data_par_0 = 8'h00;
  logic [7:0] data_par_1 = 8'h00;
  logic       valid_par_0 = 1'b0;
  logic       valid_par_1 = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       lane_sel;
  logic       synced;
  logic [3:0] err_cnt;
  logic       err_pulse;
`ifdef BYTE_UNSTRIP_CTRL_STATS_EN
  logic [15:0] word_cnt;
`endif

  byte_unstrip_ctrl dut (
    .clk_2f      (clk_2f),
    .reset       (reset),
    .data_par_0  (data_par_0),
    .data_par_1  (data_par_1),
    .valid_par_0 (valid_par_0),
    .valid_par_1 (valid_par_1),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .lane_sel    (lane_sel),
    .synced      (synced),
    .err_cnt     (err_cnt),
    .err_pulse   (err_pulse)
`ifdef BYTE_UNSTRIP_CTRL_STATS_EN
    ,
    .word_cnt    (word_cnt)
`endif
  );

  always #5 clk_2f = ~clk_2f;

  int errors = 0;
  int checks = 0;

  // Word-level reference model state
  bit          m_locked;
  int          m_com_run;
  int          m_err_run;
  int          m_err_cnt;
  bit          m_lane;
  bit          m_pend_v;
  logic [7:0]  m_pend_b;
  logic [15:0] m_words;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input bit ev, input logic [7:0] eb,
                             input bit el, input bit ep, input bit es);
    check({tag, ".valid"},  16'(valid_out), 16'(ev));
    check({tag, ".data"},   16'(data_out),  16'(eb));
    check({tag, ".lane"},   16'(lane_sel),  16'(el));
    check({tag, ".pulse"},  16'(err_pulse), 16'(ep));
    check({tag, ".synced"}, 16'(synced),    16'(es));
    check({tag, ".errcnt"}, 16'(err_cnt),   16'(m_err_cnt));
`ifdef BYTE_UNSTRIP_CTRL_STATS_EN
    check({tag, ".wordcnt"}, word_cnt, m_words);
`endif
  endtask

  task automatic model_clear();
    m_locked  = 1'b0;
    m_com_run = 0;
    m_err_run = 0;
    m_err_cnt = 0;
    m_lane    = 1'b0;
    m_pend_v  = 1'b0;
    m_pend_b  = 8'h00;
    m_words   = 16'h0000;
  endtask

  // Entered and left just after a rising edge; the edge starts a word.
  task automatic send_word(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                           input bit v0, input bit v1);
    bit         is_com;
    bit         ev;
    logic [7:0] eb;
    bit         ep;
    bit         es;
    data_par_0  = d0;
    data_par_1  = d1;
    valid_par_0 = v0;
    valid_par_1 = v1;
    @(negedge clk_2f);
    // Phase-0 cycle shows the lane 1 byte of the previous word, if any.
    if (m_pend_v) m_lane = 1'b1;
    check_cycle({tag, ".p0"}, m_pend_v, m_pend_v ? m_pend_b : IDLE, m_lane, 1'b0, m_locked);
    m_pend_v = 1'b0;

    is_com = v0 && v1 && d0 == COM && d1 == COM;
    ev = 1'b0; eb = IDLE; ep = 1'b0; es = m_locked;
    if (!m_locked) begin
      if (is_com) m_com_run++;
      else        m_com_run = 0;
    end else if (v0 && v1 && !is_com) begin
      ev = 1'b1; eb = d0; m_lane = 1'b0;
      m_pend_v = 1'b1; m_pend_b = d1;
      m_err_run = 0;
      m_words = m_words + 16'd1;
    end else if (is_com) begin
      m_err_run = 0;
    end else if (v0 != v1) begin
      ep = 1'b1;
      if (m_err_cnt < 15) m_err_cnt++;
      m_err_run++;
    end

    @(posedge clk_2f); #1;
    // While locked, phase-1 lane contents must not matter.
    if (m_locked && $urandom_range(1, 0) == 1) begin
      data_par_0  = 8'($urandom);
      data_par_1  = 8'($urandom);
      valid_par_0 = 1'($urandom);
      valid_par_1 = 1'($urandom);
    end
    @(negedge clk_2f);
    check_cycle({tag, ".p1"}, ev, eb, m_lane, ep, es);

    if (!m_locked && m_com_run == SW) begin
      m_locked = 1'b1; m_com_run = 0;
    end else if (m_locked && m_err_run >= EL) begin
      m_locked = 1'b0; m_err_run = 0; m_com_run = 0;
    end
    @(posedge clk_2f); #1;
  endtask

  task automatic com_words(input string tag, input int n);
    for (int i = 0; i < n; i++) send_word(tag, COM, COM, 1'b1, 1'b1);
  endtask

  // Assert reset across one edge, check reset values, release.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    data_par_0 = 8'h00; data_par_1 = 8'h00;
    valid_par_0 = 1'b0; valid_par_1 = 1'b0;
    @(posedge clk_2f); #1;
    check({tag, ".data"},   16'(data_out),  16'(IDLE));
    check({tag, ".valid"},  16'(valid_out), 16'd0);
    check({tag, ".lane"},   16'(lane_sel),  16'd0);
    check({tag, ".synced"}, 16'(synced),    16'd0);
    check({tag, ".errcnt"}, 16'(err_cnt),   16'd0);
    check({tag, ".pulse"},  16'(err_pulse), 16'd0);
`ifdef BYTE_UNSTRIP_CTRL_STATS_EN
    check({tag, ".wordcnt"}, word_cnt, 16'd0);
`endif
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    int kind;
    model_clear();
    repeat (2) @(posedge clk_2f);
    #1;
    do_reset("reset");

    // Lock: 4 COM words; synced rises on cycle 9 (next word's phase 0).
    com_words("lock", SW);
    send_word("w1122", 8'h11, 8'h22, 1'b1, 1'b1);
    send_word("w3344", 8'h33, 8'h44, 1'b1, 1'b1);

    // Single mismatch, then a normally forwarded word.
    send_word("mis1", 8'h01, 8'h02, 1'b1, 1'b0);
    send_word("w5566", 8'h55, 8'h66, 1'b1, 1'b1);

    // Three consecutive mismatches force resync; then relock.
    send_word("misA", 8'hA0, 8'hA1, 1'b1, 1'b0);
    send_word("misB", 8'hB0, 8'hB1, 1'b0, 1'b1);
    send_word("misC", 8'hC0, 8'hC1, 1'b1, 1'b0);
    check("resync.synced", 16'(synced), 16'd0);
    send_word("unlocked", 8'h12, 8'h34, 1'b1, 1'b1);
    com_words("relock", SW);

    // Broken COM run: lock only after the final uninterrupted run.
    do_reset("reset2");
    com_words("run3", 3);
    send_word("brk", 8'h00, 8'h00, 1'b1, 1'b1);
    com_words("run4", SW);

    // Idle and COM words while locked; err_run survives idle words only.
    send_word("idle", 8'hEE, 8'hFF, 1'b0, 1'b0);
    send_word("comskip", COM, COM, 1'b1, 1'b1);
    send_word("mis2a", 8'h10, 8'h20, 1'b1, 1'b0);
    send_word("idle2", 8'h00, 8'h00, 1'b0, 1'b0);
    send_word("mis2b", 8'h10, 8'h20, 1'b0, 1'b1);
    send_word("good", 8'h77, 8'h88, 1'b1, 1'b1);
    send_word("mis3a", 8'h10, 8'h20, 1'b1, 1'b0);
    send_word("mis3b", 8'h10, 8'h20, 1'b1, 1'b0);
    send_word("lone0", 8'h99, 8'hAA, 1'b1, 1'b1);

    // Randomised words against the model.
    for (int i = 0; i < 300; i++) begin
      if (!m_locked) begin
        if ($urandom_range(9, 0) < 8) send_word("rnd", COM, COM, 1'b1, 1'b1);
        else send_word("rnd", 8'($urandom), 8'($urandom), 1'b1, 1'b1);
      end else begin
        kind = int'($urandom_range(9, 0));
        if (kind <= 5)      send_word("rnd", 8'($urandom), 8'($urandom), 1'b1, 1'b1);
        else if (kind == 6) send_word("rnd", COM, COM, 1'b1, 1'b1);
        else if (kind == 7) send_word("rnd", 8'($urandom), 8'($urandom), 1'b0, 1'b0);
        else if (kind == 8) send_word("rnd", 8'($urandom), 8'($urandom), 1'b1, 1'b0);
        else                send_word("rnd", 8'($urandom), 8'($urandom), 1'b0, 1'b1);
      end
    end

    // Saturation: 18 more mismatch words from a clean reset.
    do_reset("reset3");
    for (int r = 0; r < 6; r++) begin
      com_words("satlock", SW);
      for (int k = 0; k < EL; k++) send_word("sat", 8'h5A, 8'hA5, 1'b1, 1'b0);
    end
    check("sat.errcnt", 16'(err_cnt), 16'd15);

    // Word counter: 5 forwarded words plus 2 COM words.
    do_reset("reset4");
    com_words("stlock", SW);
    for (int k = 0; k < 5; k++) send_word("st", 8'(k + 1), 8'(k + 16), 1'b1, 1'b1);
    com_words("stcom", 2);
`ifdef BYTE_UNSTRIP_CTRL_STATS_EN
    check("stats.wordcnt", word_cnt, 16'd5);
`endif

    // Reset mid-word: lane 0 byte is out, then reset hits during phase 1.
    data_par_0 = 8'hA1; data_par_1 = 8'hB2;
    valid_par_0 = 1'b1; valid_par_1 = 1'b1;
    @(posedge clk_2f); #1;
    check("mid.valid", 16'(valid_out), 16'd1);
    check("mid.data",  16'(data_out),  16'hA1);
    do_reset("midreset");
    com_words("fresh", SW);
    send_word("fresh.w", 8'hC3, 8'h3C, 1'b1, 1'b1);
    send_word("fresh.idle", 8'h00, 8'h00, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
